// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default bit period, frame shape.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // 16 MHz core clock / 115200 baud, shared with the transmit side.
  localparam int UART_CLOCK_PER_BAUD = 138;
  localparam int DATA_BITS           = 8;
  localparam int STOP_BITS           = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // 2-of-3 vote used when sample filtering is enabled.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input pin.
// Latency: 2 cycles from i_async to o_sync.
// Backpressure: none; samples every cycle.
// Ports: i_clk, i_reset (sync, active-high), i_async (raw pin), o_sync (synchronised).
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with a one-entry read buffer, framing-error pulse and sticky overrun.
// Latency: o_data_ready rises CLOCK_PER_BAUD/2 + 9*CLOCK_PER_BAUD + 1 cycles after start detect (+1 with majority).
// Backpressure: none on the line; an unread byte is overwritten by the next one and flags o_overrun.
// Ports: i_clk, i_reset (sync, active-high), i_rx_unsafe (raw pin, idle high), i_read_enable (consume strobe),
//        o_read_data/o_data_ready (buffered byte), o_frame_err (1-cycle pulse), o_overrun (sticky until read).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BAUD = UART_CLOCK_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_unsafe,
  input  logic       i_read_enable,
  output logic [7:0] o_read_data,
  output logic       o_data_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int             CW   = $clog2(CLOCK_PER_BAUD + 1);
  localparam int             IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  HALF = CW'(CLOCK_PER_BAUD / 2);
  localparam logic [CW-1:0]  FULL = CW'(CLOCK_PER_BAUD);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rx_unsafe),
    .o_sync  (rx_s)
  );

  uart_rx_state_t         state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rdy_q, rdy_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic counting;
  logic expire;
  logic take;     // act on a bit sample this cycle
  logic smp;      // the sampled bit value
  logic deliver;

  assign counting = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  // The counter expires when its decrement reaches 0; the expiry cycle is the bit centre.
  assign expire   = counting && (cnt_q == CW'(1));

`ifdef UART_RX_MAJORITY_EN
  // Vote over the cycles before, at and after the bit centre; act one cycle late.
  // The counter keeps its grid, so only the decision moves.
  logic rx_d1_q, rx_d2_q, pend_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_d1_q <= 1'b1;
      rx_d2_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      rx_d1_q <= rx_s;
      rx_d2_q <= rx_d1_q;
      pend_q  <= expire;
    end
  end

  assign take = pend_q;
  assign smp  = maj3(rx_d2_q, rx_d1_q, rx_s);
`else
  assign take = expire;
  assign smp  = rx_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    ferr_d    = 1'b0;

    if (counting) begin
      cnt_d = expire ? FULL : (cnt_q - CW'(1));
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (take) begin
          if (smp) begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end else begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (take) begin
          shift_d = {smp, shift_q[DATA_BITS-1:1]};  // LSB arrives first
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (take) begin
          if (smp) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low break stays here, so it reports only one error.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read buffer: a deliver in the same cycle as a read wins and is not an overrun.
  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    ovr_d  = ovr_q;
    if (i_read_enable && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (deliver) begin
      data_d = shift_q;
      rdy_d  = 1'b1;
      if (rdy_q && !i_read_enable) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_read_data  = data_q;
  assign o_data_ready = rdy_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven on the pin, expected bytes and
// arrival cycles are queued at send time, and a negedge monitor pops and checks
// every new byte the receiver presents.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = UART_CLOCK_PER_BAUD;
  localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_unsafe = 1'b1;
  logic       i_read_enable = 1'b0;
  logic [7:0] o_read_data;
  logic       o_data_ready;
  logic       o_frame_err;
  logic       o_overrun;

  uart_rx #(.CLOCK_PER_BAUD(C)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_unsafe   (i_rx_unsafe),
    .i_read_enable (i_read_enable),
    .o_read_data   (o_read_data),
    .o_data_ready  (o_data_ready),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         ferr_cnt = 0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a new byte is a rise of o_data_ready or a data change while it stays high.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_frame_err === 1'b1) ferr_cnt++;
    if (o_data_ready === 1'b1 && (!prev_rdy || o_read_data !== prev_data)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_byte: got %02h, required none (cycle %0d)", o_read_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", {24'h0, o_read_data}, {24'h0, e.data});
        chk("rx_cycle", cyc, e.at);
      end
    end
    prev_rdy  = o_data_ready;
    prev_data = o_read_data;
  end

  task automatic bit_time(input logic v);
    i_rx_unsafe = v;
    repeat (C) @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx_unsafe = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Pin falls now; 2 sync cycles, then H + 9C to the stop sample, then 1 to the output.
  task automatic send(input logic [7:0] b, input logic stop_v, input bit expect_byte);
    if (expect_byte) exp_q.push_back('{data: b, at: cyc + 2 + H + 9 * C + 1 + EXTRA});
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_v);
    i_rx_unsafe = 1'b1;
  endtask

  task automatic read_byte(input string name);
    i_read_enable = 1'b1;
    @(posedge i_clk);
    #1;
    i_read_enable = 1'b0;
    chk(name, {31'h0, o_data_ready}, 32'h0);
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  {31'h0, o_data_ready}, 32'h0);
    chk({tag, "_data"}, {24'h0, o_read_data},  32'h0);
    chk({tag, "_ferr"}, {31'h0, o_frame_err},  32'h0);
    chk({tag, "_ovr"},  {31'h0, o_overrun},    32'h0);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'hA5;

    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_vals("reset");
    i_reset = 1'b0;
    idle(5);

    // Clean byte with exact arrival cycle.
    send(8'h55, 1'b1, 1'b1);
    idle(C);
    drained("rx_55_seen");
    chk("no_ferr_55", ferr_cnt, 32'h0);
    chk("no_ovr_55", {31'h0, o_overrun}, 32'h0);
    read_byte("read_55_fall");

    send(8'hA3, 1'b1, 1'b1);
    idle(C);
    drained("rx_a3_seen");
    read_byte("read_a3_fall");

    send(8'h00, 1'b1, 1'b1);
    idle(C);
    drained("rx_00_seen");
    read_byte("read_00_fall");

    // Two back-to-back bytes without a read: second overwrites, overrun sticks.
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    idle(C);
    drained("rx_11_22_seen");
    chk("ovr_set", {31'h0, o_overrun}, 32'h1);
    chk("ovr_data", {24'h0, o_read_data}, 32'h22);
    read_byte("read_22_fall");
    chk("ovr_clr", {31'h0, o_overrun}, 32'h0);

    // Bad stop bit followed by a 3-bit break: one error, no byte.
    send(8'h7E, 1'b0, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    idle(C);
    chk("ferr_once", ferr_cnt, 32'h1);
    chk("ferr_no_rdy", {31'h0, o_data_ready}, 32'h0);

    send(8'h42, 1'b1, 1'b1);
    idle(C);
    drained("rx_42_seen");
    chk("ferr_still_once", ferr_cnt, 32'h1);
    read_byte("read_42_fall");

    // Short low glitch on an idle line is rejected.
    i_rx_unsafe = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    idle(2 * C);
    chk("glitch_no_rdy", {31'h0, o_data_ready}, 32'h0);
    chk("glitch_no_ferr", ferr_cnt, 32'h1);

    // Receiver must be back in IDLE: next frame keeps exact timing. Leave it unread.
    send(8'h3C, 1'b1, 1'b1);
    idle(C);
    drained("rx_3c_seen");
    chk("rdy_before_reset", {31'h0, o_data_ready}, 32'h1);

    // Reset in the middle of bit 4 of a frame.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(partial[i]);
    i_rx_unsafe = partial[4];
    repeat (H) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_rx_unsafe = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_vals("midreset");
    i_reset = 1'b0;
    idle(2 * C);
    chk_reset_vals("postreset");
    chk("reset_no_ferr", ferr_cnt, 32'h1);

    send(8'hC9, 1'b1, 1'b1);
    idle(C);
    drained("rx_c9_seen");
    read_byte("read_c9_fall");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
